// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SETUP,
    PULSE,
    GAP,
    LOAD,
    DONE
  } dynphase_state_t;

  localparam int PLL_MAX_CH          = 4;
  localparam int PHASE_STEPS_PER_DIV = 8;

  // One output-divider count is split into eight fine VCO phase steps.
  function automatic int f_period(input int div);
    return div * PHASE_STEPS_PER_DIV;
  endfunction

endpackage

// File: rtl/ecp5pll_dynphase_if.sv
// Request/status handshake between control logic and the phase-shift sequencer.
interface ecp5pll_dynphase_if #(
  parameter int STEP_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_chan;
  logic [STEP_W-1:0] req_steps;
  logic              req_load;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, req_chan, req_steps, req_load,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_chan, req_steps, req_load,
    output req_ready, done, err, busy
  );

endinterface

// File: rtl/ecp5pll_cyc_timer.sv
// Loadable down-counter; zero is valid in the load cycle so an interval of L
// cycles is obtained by loading L-1 on entry and leaving when zero is seen.
module ecp5pll_cyc_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = load ? (load_val == '0) : (cnt == '0);

endmodule

// File: rtl/ecp5pll_dynphase.sv
// Dynamic phase-shift sequencer: turns signed per-channel step requests into
// timed phasesel/phasedir/phasestep/phaseloadreg activity and tracks positions.
module ecp5pll_dynphase
  import ecp5pll_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int STEP_W       = 8,
  parameter int PERIOD0      = f_period(5),
  parameter int PERIOD1      = f_period(5),
  parameter int PERIOD2      = f_period(5),
  parameter int PERIOD3      = f_period(5),
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset,
  ecp5pll_dynphase_if.slave          req,
  output logic [CHANNELS*STEP_W-1:0] pos_o,
  output logic [1:0]                 phasesel,
  output logic                       phasedir,
  output logic                       phasestep,
  output logic                       phaseloadreg,
  input  logic                       locked
);

  localparam int TIMER_W = $clog2(LOCK_TIMEOUT + SETUP_CYC + PULSE_CYC + GAP_CYC + 1);
  localparam int unsigned PERIOD_TAB [PLL_MAX_CH] = '{PERIOD0, PERIOD1, PERIOD2, PERIOD3};
  localparam logic [2:0] CH_LIM = 3'(CHANNELS);

  dynphase_state_t   state;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        chan_q;
  logic              dir_q;
  logic              load_q;
  logic [STEP_W-1:0] remaining;
  logic              lock_lost;
  logic [1:0]        lock_sync_q;
  logic              lock_sync;
  logic              lost_now;
  logic              tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic              tmr_zero;
  logic              step_fire;
  logic              req_dir;
  logic [STEP_W-1:0] req_mag;
  logic              chan_bad;

  assign req.req_ready = req_ready_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign req.busy      = busy_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], locked};
    end
  end

  assign lock_sync = lock_sync_q[1];
  assign lost_now  = lock_lost | ~lock_sync;

  // The most negative request has no positive twin, so the magnitude is unsigned.
  assign req_dir  = req.req_steps[STEP_W-1];
  assign req_mag  = req_dir ? (~req.req_steps + STEP_W'(1)) : req.req_steps;
  assign chan_bad = {1'b0, req.req_chan} >= CH_LIM;

  assign step_fire = (state == PULSE) && tmr_zero;

  ecp5pll_cyc_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk_i    (clk_i),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      chan_q       <= '0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      remaining    <= '0;
      lock_lost    <= 1'b0;
      tmr_load     <= 1'b0;
      tmr_val      <= '0;
      phasesel     <= '0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b0;
      phaseloadreg <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      tmr_load <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            lock_lost   <= 1'b0;
            chan_q      <= req.req_chan;
            dir_q       <= req_dir;
            load_q      <= req.req_load;
            remaining   <= req_mag;
            if (chan_bad) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (req_mag == '0 && !req.req_load) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              phasesel <= req.req_chan;
              phasedir <= req_dir;
              tmr_load <= 1'b1;
              if (lock_sync) begin
                tmr_val <= TIMER_W'(SETUP_CYC - 1);
                state   <= SETUP;
              end else begin
                tmr_val <= TIMER_W'(LOCK_TIMEOUT - 1);
                state   <= WAIT_LOCK;
              end
            end
          end
        end

        WAIT_LOCK: begin
          if (lock_sync) begin
            tmr_load <= 1'b1;
            tmr_val  <= TIMER_W'(SETUP_CYC - 1);
            state    <= SETUP;
          end else if (tmr_zero) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        SETUP: begin
          if (!lock_sync) lock_lost <= 1'b1;
          if (tmr_zero) begin
            if (lost_now) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              tmr_load <= 1'b1;
              tmr_val  <= TIMER_W'(PULSE_CYC - 1);
              if (remaining == '0) begin
                phaseloadreg <= 1'b1;
                state        <= LOAD;
              end else begin
                phasestep <= 1'b1;
                state     <= PULSE;
              end
            end
          end
        end

        // A started pulse always runs to full width; lock loss is acted on after the gap.
        PULSE: begin
          if (!lock_sync) lock_lost <= 1'b1;
          if (tmr_zero) begin
            phasestep <= 1'b0;
            tmr_load  <= 1'b1;
            tmr_val   <= TIMER_W'(GAP_CYC - 1);
            state     <= GAP;
          end
        end

        GAP: begin
          if (!lock_sync) lock_lost <= 1'b1;
          if (tmr_zero) begin
            remaining <= remaining - STEP_W'(1);
            if (lost_now) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (remaining != STEP_W'(1)) begin
              phasestep <= 1'b1;
              tmr_load  <= 1'b1;
              tmr_val   <= TIMER_W'(PULSE_CYC - 1);
              state     <= PULSE;
            end else if (load_q) begin
              phaseloadreg <= 1'b1;
              tmr_load     <= 1'b1;
              tmr_val      <= TIMER_W'(PULSE_CYC - 1);
              state        <= LOAD;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end

        LOAD: begin
          if (tmr_zero) begin
            phaseloadreg <= 1'b0;
            done_q       <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Each channel wraps within its own period, so positions stay in 0..PERIOD-1.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_pos
    localparam logic [STEP_W-1:0] PMAX = STEP_W'(PERIOD_TAB[c] - 1);
    logic [STEP_W-1:0] pos;

    always_ff @(posedge clk_i) begin
      if (reset) begin
        pos <= '0;
      end else if (step_fire && chan_q == 2'(c)) begin
        if (dir_q) begin
          pos <= (pos == '0) ? PMAX : pos - STEP_W'(1);
        end else begin
          pos <= (pos == PMAX) ? '0 : pos + STEP_W'(1);
        end
      end
    end

    assign pos_o[c*STEP_W +: STEP_W] = pos;
  end

endmodule

// File: tb/tb_ecp5pll_dynphase.sv
// Directed bench for ecp5pll_dynphase with default parameters; expected values
// are worked out by hand from the sequencer timing.
module tb_ecp5pll_dynphase;

  logic        clk_i;
  logic        reset;
  logic        locked;
  logic [31:0] pos_o;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        phaseloadreg;

  int checks;
  int errors;

  int done_cyc;
  int pulses;
  int step_hi;
  int load_hi;
  int first_rise;
  int pin_err;
  int ready_c1;
  int busy_c1;

  ecp5pll_dynphase_if #(.STEP_W(8)) req_if ();

  ecp5pll_dynphase dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .req          (req_if),
    .pos_o        (pos_o),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .locked       (locked)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issues one request and watches the pins until done or the cycle budget runs out.
  // Cycle 1 is the cycle right after the accepting edge.
  task automatic applyStimulus(input logic [1:0] chan, input logic [7:0] steps,
                               input logic load, input int drop_pulse, input int limit);
    logic prev_step;
    req_if.req_valid = 1'b1;
    req_if.req_chan  = chan;
    req_if.req_steps = steps;
    req_if.req_load  = load;
    @(posedge clk_i);
    #1;
    req_if.req_valid = 1'b0;
    done_cyc   = 0;
    pulses     = 0;
    step_hi    = 0;
    load_hi    = 0;
    first_rise = 0;
    pin_err    = 0;
    prev_step  = 1'b0;
    ready_c1   = int'(req_if.req_ready);
    busy_c1    = int'(req_if.busy);
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (phasestep && !prev_step) begin
        pulses++;
        if (first_rise == 0) first_rise = cyc;
      end
      if (phasestep) step_hi++;
      if (phaseloadreg) load_hi++;
      if ((phasestep || phaseloadreg) && (phasesel != chan || phasedir != steps[7])) pin_err++;
      if (drop_pulse != 0 && pulses == drop_pulse && phasestep) locked = 1'b0;
      prev_step = phasestep;
      if (req_if.done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (done_cyc == 0) $display("[TB] no done within %0d cycles", limit);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    locked = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_chan  = 2'd0;
    req_if.req_steps = 8'd0;
    req_if.req_load  = 1'b0;
    tick(3);
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_ready", 32'(req_if.req_ready), 32'd1);
    checkOutput("rst_busy",  32'(req_if.busy), 32'd0);
    checkOutput("rst_done",  32'(req_if.done), 32'd0);
    checkOutput("rst_err",   32'(req_if.err), 32'd0);
    checkOutput("rst_pos",   pos_o, 32'd0);
    checkOutput("rst_step",  32'(phasestep), 32'd0);
    tick(3);

    $display("[TB] chan1 +3 steps");
    applyStimulus(2'd1, 8'd3, 1'b0, 0, 100);
    checkOutput("t1_done_cyc", 32'(done_cyc), 32'd27);
    checkOutput("t1_pulses", 32'(pulses), 32'd3);
    checkOutput("t1_step_hi", 32'(step_hi), 32'd12);
    checkOutput("t1_first_rise", 32'(first_rise), 32'd3);
    checkOutput("t1_pins", 32'(pin_err), 32'd0);
    checkOutput("t1_ready_c1", 32'(ready_c1), 32'd0);
    checkOutput("t1_busy_c1", 32'(busy_c1), 32'd1);
    checkOutput("t1_ready_in_done", 32'(req_if.req_ready), 32'd0);
    checkOutput("t1_pos1", 32'(pos_o[15:8]), 32'd3);
    checkOutput("t1_err", 32'(req_if.err), 32'd0);
    tick(1);
    checkOutput("t1_ready_after", 32'(req_if.req_ready), 32'd1);
    checkOutput("t1_done_width", 32'(req_if.done), 32'd0);
    checkOutput("t1_sel_hold", 32'(phasesel), 32'd1);

    $display("[TB] chan0 -1 then +1");
    applyStimulus(2'd0, 8'hFF, 1'b0, 0, 100);
    checkOutput("t2_done_cyc", 32'(done_cyc), 32'd11);
    checkOutput("t2_pins", 32'(pin_err), 32'd0);
    checkOutput("t2_pos0_wrap", 32'(pos_o[7:0]), 32'd39);
    tick(1);
    checkOutput("t2_dir_hold", 32'(phasedir), 32'd1);
    applyStimulus(2'd0, 8'h01, 1'b0, 0, 100);
    checkOutput("t2_pos0_back", 32'(pos_o[7:0]), 32'd0);
    tick(1);

    $display("[TB] chan2 -128");
    applyStimulus(2'd2, 8'h80, 1'b0, 0, 1100);
    checkOutput("t3_pulses", 32'(pulses), 32'd128);
    checkOutput("t3_done_cyc", 32'(done_cyc), 32'd1027);
    checkOutput("t3_pos2", 32'(pos_o[23:16]), 32'd32);
    checkOutput("t3_pins", 32'(pin_err), 32'd0);
    tick(1);

    $display("[TB] lock timeout");
    locked = 1'b0;
    tick(4);
    applyStimulus(2'd3, 8'd2, 1'b0, 0, 1100);
    checkOutput("t4_pulses", 32'(pulses), 32'd0);
    checkOutput("t4_err", 32'(req_if.err), 32'd1);
    checkOutput("t4_done_window", 32'(done_cyc >= 1023 && done_cyc <= 1027), 32'd1);
    checkOutput("t4_pos3", 32'(pos_o[31:24]), 32'd0);
    tick(1);
    checkOutput("t4_err_sticky", 32'(req_if.err), 32'd1);
    locked = 1'b1;
    tick(4);
    applyStimulus(2'd3, 8'd0, 1'b0, 0, 20);
    checkOutput("t4_zero_done_cyc", 32'(done_cyc), 32'd1);
    checkOutput("t4_err_cleared", 32'(req_if.err), 32'd0);
    tick(1);

    $display("[TB] lock loss during pulse 2 of 5");
    applyStimulus(2'd1, 8'd5, 1'b0, 2, 100);
    checkOutput("t5_pulses", 32'(pulses), 32'd2);
    checkOutput("t5_step_hi", 32'(step_hi), 32'd8);
    checkOutput("t5_done_cyc", 32'(done_cyc), 32'd19);
    checkOutput("t5_err", 32'(req_if.err), 32'd1);
    checkOutput("t5_pos1", 32'(pos_o[15:8]), 32'd5);
    locked = 1'b1;
    tick(4);

    $display("[TB] zero steps with load");
    applyStimulus(2'd0, 8'd0, 1'b1, 0, 50);
    checkOutput("t6_done_cyc", 32'(done_cyc), 32'd7);
    checkOutput("t6_load_hi", 32'(load_hi), 32'd4);
    checkOutput("t6_pulses", 32'(pulses), 32'd0);
    checkOutput("t6_pins", 32'(pin_err), 32'd0);
    checkOutput("t6_err", 32'(req_if.err), 32'd0);
    checkOutput("t6_pos_all", pos_o, 32'h0020_0500);
    tick(1);

    $display("[TB] reset mid-pulse");
    req_if.req_valid = 1'b1;
    req_if.req_chan  = 2'd2;
    req_if.req_steps = 8'd2;
    req_if.req_load  = 1'b1;
    tick(1);
    req_if.req_valid = 1'b0;
    tick(2);
    checkOutput("t7_in_pulse", 32'(phasestep), 32'd1);
    checkOutput("t7_sel_pre", 32'(phasesel), 32'd2);
    reset = 1'b1;
    tick(1);
    checkOutput("t7_step", 32'(phasestep), 32'd0);
    checkOutput("t7_load", 32'(phaseloadreg), 32'd0);
    checkOutput("t7_sel", 32'(phasesel), 32'd0);
    checkOutput("t7_dir", 32'(phasedir), 32'd0);
    checkOutput("t7_pos", pos_o, 32'd0);
    checkOutput("t7_ready", 32'(req_if.req_ready), 32'd1);
    checkOutput("t7_busy", 32'(req_if.busy), 32'd0);
    checkOutput("t7_done", 32'(req_if.done), 32'd0);
    checkOutput("t7_err", 32'(req_if.err), 32'd0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
